// File: rtl/i2c_txn_arbiter.sv
// Round-robin sequencer sharing one byte-level I2C master engine among
// N_REQ requesters. One single-byte transaction at a time, with NACK retry,
// a watchdog abort and a per-requester completion pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no transaction; arbitrate among req_valid
// ISSUE    | m_start pulse to the engine, watchdog reloaded
// WAIT     | engine busy; watch for m_done, NACK retry, watchdog expiry
// COMPLETE | req_done pulse to the winner, rotate pointer, release grant
module i2c_txn_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int MAX_RETRY      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [7*N_REQ-1:0]   req_addr,
  input  logic [N_REQ-1:0]     req_rw,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     req_grant,
  output logic [N_REQ-1:0]     req_done,
  output logic                 rsp_err,
  output logic [7:0]           rsp_rdata,
  output logic                 m_start,
  output logic                 m_abort,
  output logic [6:0]           m_addr,
  output logic                 m_rw,
  output logic [7:0]           m_wdata,
  input  logic                 m_done,
  input  logic                 m_ack_err,
  input  logic [7:0]           m_rdata,
  output logic                 busy,
  output logic [1:0]           debug_state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  // The watchdog is a down-counter: loaded in ISSUE, terminal count at 0
  // lands on the TIMEOUT_CYCLES-th WAIT cycle.
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] PTR_RST    = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT     = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic [N_REQ-1:0]  grant_d, done_d;
  logic              err_d, start_d, abort_d, rw_d;
  logic [7:0]        rdata_d, wdata_d;
  logic [6:0]        addr_d;

  logic              arb_found;
  logic [IW-1:0]     arb_idx;
  logic [IW:0]       cand;

  logic [6:0]        sel_addr;
  logic              sel_rw;
  logic [7:0]        sel_wdata;
  logic [N_REQ-1:0]  sel_onehot;

  // Rotating-priority scan: first pending requester after the last winner.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (!arb_found && req_valid[cand[IW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IW-1:0];
      end
    end
  end

  // Winner's request fields and one-hot grant vector.
  always_comb begin
    sel_addr   = '0;
    sel_rw     = 1'b0;
    sel_wdata  = '0;
    sel_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_addr      = req_addr[7*i +: 7];
        sel_rw        = req_rw[i];
        sel_wdata     = req_wdata[8*i +: 8];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and next-output decode; every output is a flop fed from here.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    retry_d = retry_q;
    timer_d = timer_q;
    grant_d = req_grant;
    done_d  = '0;
    err_d   = rsp_err;
    rdata_d = rsp_rdata;
    start_d = 1'b0;
    abort_d = 1'b0;
    addr_d  = m_addr;
    rw_d    = m_rw;
    wdata_d = m_wdata;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = ISSUE;
          win_d   = arb_idx;
          grant_d = sel_onehot;
          addr_d  = sel_addr;
          rw_d    = sel_rw;
          wdata_d = sel_wdata;
          retry_d = '0;
          start_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = TIMER_LOAD;
      end
      WAIT: begin
        // m_done takes priority over a watchdog expiry in the same cycle
        if (m_done) begin
          if (!m_ack_err) begin
            err_d   = 1'b0;
            if (m_rw) rdata_d = m_rdata;
            done_d  = req_grant;
            state_d = COMPLETE;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            start_d = 1'b1;
            state_d = ISSUE;
          end else begin
            err_d   = 1'b1;
            done_d  = req_grant;
            state_d = COMPLETE;
          end
        end else if (timer_q == '0) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
          done_d  = req_grant;
          state_d = COMPLETE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      COMPLETE: begin
        ptr_d   = win_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RST;
      win_q     <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      req_grant <= '0;
      req_done  <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      m_start   <= 1'b0;
      m_abort   <= 1'b0;
      m_addr    <= '0;
      m_rw      <= 1'b0;
      m_wdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      req_grant <= grant_d;
      req_done  <= done_d;
      rsp_err   <= err_d;
      rsp_rdata <= rdata_d;
      m_start   <= start_d;
      m_abort   <= abort_d;
      m_addr    <= addr_d;
      m_rw      <= rw_d;
      m_wdata   <= wdata_d;
      busy      <= (state_d != IDLE);
    end
  end

  assign debug_state = state_q;

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one byte-level I2C master engine among N_REQ requesters (e.g. switch-poll, LED-write and sensor clients on the board-to-board bus).
- Runs one single-byte transaction at a time: captures the winner's address, R/W bit and write data, then starts the engine.
- Retries on address NACK, enforces a watchdog timeout, and returns read data plus a completion/error pulse to the granted requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 200000, maximum number of WAIT cycles (2 ms at 100 MHz) before abort.
- MAX_RETRY, 2, number of re-issues after m_ack_err before error is reported.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  N_REQ  per-requester request. Held high until that requester's req_done.
- req_addr  in  7*N_REQ  7-bit slave address, requester i at [7i+6:7i].
- req_rw  in  N_REQ  1 = read, 0 = write.
- req_wdata  in  8*N_REQ  write byte, requester i at [8i+7:8i].
- req_grant  out  N_REQ  one-hot grant, held ISSUE..COMPLETE.
- req_done  out  N_REQ  one-cycle completion pulse to the granted requester.
- rsp_err  out  1  valid with req_done. 1 = NACK after retries, or timeout.
- rsp_rdata  out  8  read byte, valid with req_done. Held until next completion.
- m_start  out  1  one-cycle start pulse to the master engine.
- m_abort  out  1  one-cycle abort pulse on timeout (engine issues STOP).
- m_addr  out  7  slave address to the engine.
- m_rw  out  1  R/W bit to the engine.
- m_wdata  out  8  write byte to the engine.
- m_done  in  1  engine completion pulse.
- m_ack_err  in  1  valid with m_done. 1 = slave NACKed.
- m_rdata  in  8  valid with m_done.
- busy  out  1  state != IDLE.
- debug_state  out  2  encoded state.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state IDLE, retry count 0, timer 0, last-grant pointer N_REQ-1 (so requester 0 wins first).
- States: IDLE=0, ISSUE=1, WAIT=2, COMPLETE=3.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning upward from (ptr+1) mod N_REQ with wrap.
  - Next cycle: req_grant = onehot(winner); m_addr, m_rw and m_wdata latched from the winner's fields; retry=0; state=ISSUE.
  - Latency is 1 cycle from req_valid sampled to req_grant.
- ISSUE:
  - m_start=1 for exactly this cycle; timer cleared; next state WAIT.
  - m_done is ignored in ISSUE.
- WAIT:
  - Timer increments every cycle.
  - On m_done with m_ack_err=0: latch rsp_rdata=m_rdata (reads only; writes leave rsp_rdata unchanged), rsp_err=0, go to COMPLETE.
  - On m_done with m_ack_err=1 and retry<MAX_RETRY: retry+1, go to ISSUE with the same latched fields.
  - On m_done with m_ack_err=1 and retry==MAX_RETRY: rsp_err=1, go to COMPLETE.
  - If timer reaches TIMEOUT_CYCLES-1 without m_done: m_abort=1 for one cycle, rsp_err=1, go to COMPLETE.
  - If m_done and the timeout terminal count occur in the same cycle, m_done wins and there is no abort.
- COMPLETE:
  - req_done[winner]=1 for one cycle, with rsp_err and rsp_rdata valid in the same cycle.
  - ptr=winner.
  - The next cycle: req_grant=0, state=IDLE.
  - A new grant is possible no earlier than 2 cycles after req_done.
- Requester protocol:
  - Dropping req_valid while granted does not abort; the transaction runs to completion and req_done is still pulsed.
  - req_* fields are sampled only at grant.
- Fairness: a requester that keeps req_valid high is served at most once per rotation while others are pending.
- Timer width: $clog2(TIMEOUT_CYCLES). It never wraps, because WAIT exits at the terminal count.
- Reset asserted mid-transaction: immediate return to reset values at the next clk edge. No m_abort is generated; the engine is reset by the same rst.
- m_done outside WAIT is ignored, and is not counted as an error.

Test Plan:
- Single read: req_valid=0001, addr 0x57, rw=1. Engine returns m_done with m_rdata=0xA5, ack_err=0 → grant=0001 one cycle later, one m_start, req_done=0001, rsp_rdata=0xA5, rsp_err=0.
- Round-robin: req_valid=1111 held for 8 transactions → grant order 0,1,2,3,0,1,2,3, with each req_done before the next grant.
- NACK retry: engine gives ack_err=1 twice, then 0 with rdata 0x3C → 3 m_start pulses, rsp_err=0, rsp_rdata=0x3C. With ack_err=1 three times → 3 m_start pulses, rsp_err=1.
- Timeout: TIMEOUT_CYCLES=16, engine never sends m_done → m_abort at the 16th WAIT cycle, req_done with rsp_err=1, returns to IDLE.
- Simultaneous m_done at the timeout terminal count → no m_abort, rsp_err=m_ack_err.
- Mid-transaction rst in WAIT → next cycle all outputs 0, busy=0. With req_valid=0100 afterwards, requester 2 is granted and the pointer restarts from N_REQ-1.
